rvb_req_issuer: RTL and testbench
=================================

// Module: rvb_req_issuer
// PURPOSE
//  Initiator side of the rvb din/dout valid-ready protocol. Takes operand commands from an
//  upstream queue, drives din_* of one rvb compute unit (bmatxor, clmul, ...), tracks in-flight
//  ops and pairs each dout_rd with its operands and sequence number on a result stream. Used in
//  the rvb SoC wrapper and as the reusable stimulus/collect core of unit benches.
// PARAMETERS
//  XLEN          64  operand/result width
//  MAX_INFLIGHT  4   max ops accepted but not yet retired; power of 2, >=2
//  RES_DEPTH     2   result FIFO entries, >=1
//  SEQW          16  sequence-number width
// PORTS
//  clock       in   1     clock
//  reset       in   1     synchronous, active-low reset
//  cmd_valid   in   1     command available
//  cmd_ready   out  1     command accepted when cmd_valid&&cmd_ready
//  cmd_rs1     in   XLEN  operand 1
//  cmd_rs2     in   XLEN  operand 2
//  cmd_insn30  in   1     insn bit 30 (variant select)
//  din_valid   out  1     request to unit
//  din_ready   in   1     unit accepts request
//  din_rs1     out  XLEN  request operand 1
//  din_rs2     out  XLEN  request operand 2
//  din_insn30  out  1     request variant
//  dout_valid  in   1     unit result available
//  dout_ready  out  1     issuer accepts result
//  dout_rd     in   XLEN  unit result
//  res_valid   out  1     paired result available
//  res_ready   in   1     downstream accepts result
//  res_rd      out  XLEN  result
//  res_rs1     out  XLEN  operand 1 of that op
//  res_rs2     out  XLEN  operand 2 of that op
//  res_insn30  out  1     variant of that op
//  res_seq     out  SEQW  sequence number of that op
//  inflight    out  log2(MAX_INFLIGHT)+1  ops accepted, not retired
//  err_spurious out 1     sticky: dout beat with no op in flight
// BEHAVIOUR
//  - Reset: reset reset, synchronous, active-low; clock clock. While reset==0 on a posedge:
//    din_valid=0, res_valid=0, inflight=0, seq=0, err_spurious=0, all FIFOs empty; din_*/res_*
//    data don't-care. Reset mid-operation discards all state; late dout beats after reset
//    with inflight==0 set err_spurious.
//  - Issue stage: single register. cmd_ready = (!din_valid || din_ready) && inflight<MAX_INFLIGHT
//    (combinational). On cmd fire: din_* load cmd_*, din_valid<=1 next cycle (1-cycle latency);
//    shadow FIFO pushes {rs1,rs2,insn30,seq}; seq<=seq+1 mod 2^SEQW. din_* stable while
//    din_valid && !din_ready. din fire without new cmd -> din_valid<=0.
//  - Back-to-back: din fire and cmd fire same cycle -> din_valid stays 1, full throughput.
//  - dout_ready = (res_count<RES_DEPTH) (combinational from registered count; no
//    same-cycle pop credit). On dout fire with shadow non-empty: pop shadow, push
//    {dout_rd,shadow head} into result FIFO. In-order pairing; unit is in-order.
//  - dout fire with shadow empty: beat dropped, no push, err_spurious<=1 (sticky until reset).
//  - inflight: +1 on cmd fire, -1 on non-spurious dout fire, unchanged when both same cycle.
//    Never exceeds MAX_INFLIGHT; cmd_ready=0 at MAX_INFLIGHT even if dout fires that cycle.
//  - Result FIFO: res_* = head entry, res_valid = non-empty; pop on res_valid&&res_ready;
//    push and pop same cycle allowed when non-full; count unchanged. Min latency dout fire
//    -> res_valid = 1 cycle. res_* stable while res_valid && !res_ready.
//  - Shadow FIFO depth MAX_INFLIGHT; cannot overflow given cmd_ready gating.
// TESTING
//  - Reset: hold reset=0 3 cycles with cmd_valid=1 -> din_valid=0,res_valid=0,inflight=0,
//    cmd_ready=0 during reset; first cmd after release appears on din next cycle, seq 0.
//  - Streaming: 1000 cmds, din_ready=1, 0-cycle unit -> one din fire/cycle after fill,
//    res_seq 0..999 in order, res_rd matches golden model, res_rs1/rs2 echo inputs.
//  - Credit limit: MAX_INFLIGHT=4, dout_valid=0 -> exactly 4 cmds accepted, inflight=4,
//    cmd_ready=0; one dout beat -> inflight 3, one more cmd accepted.
//  - Backpressure: res_ready=0 -> after RES_DEPTH results dout_ready=0; random din_ready,
//    dout/res_ready (75%/87%) vs 8-cycle unit -> no loss/dup, din_* stable while stalled.
//  - Spurious: dout_valid=1 with inflight=0 -> err_spurious=1 next cycle, no res_valid, stays 1.
//  - Wrap: SEQW=4, 40 cmds -> res_seq sequence 0..15,0..15,0..7.

Source files
------------

// File: rtl/rvb_req_issuer.sv
// rvb_req_issuer: issues operand commands to an rvb unit over din, pairs each dout beat with its operands and sequence number on res.
// Ports:
//   clock, reset                      clock, synchronous active-low reset
//   cmd_valid/ready, cmd_rs1/rs2/insn30   upstream command stream
//   din_valid/ready, din_rs1/rs2/insn30   request to the compute unit (registered)
//   dout_valid/ready, dout_rd             result beat from the unit
//   res_valid/ready, res_rd/rs1/rs2/insn30/seq   paired result stream
//   inflight                          ops accepted but not yet retired
//   err_spurious                      sticky flag: dout beat arrived with nothing in flight
module rvb_req_issuer #(
    parameter int XLEN = 64,
    parameter int MAX_INFLIGHT = 4,
    parameter int RES_DEPTH = 2,
    parameter int SEQW = 16,
    localparam int IW = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [XLEN-1:0] cmd_rs1,
    input  logic [XLEN-1:0] cmd_rs2,
    input  logic            cmd_insn30,
    output logic            din_valid,
    input  logic            din_ready,
    output logic [XLEN-1:0] din_rs1,
    output logic [XLEN-1:0] din_rs2,
    output logic            din_insn30,
    input  logic            dout_valid,
    output logic            dout_ready,
    input  logic [XLEN-1:0] dout_rd,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_rd,
    output logic [XLEN-1:0] res_rs1,
    output logic [XLEN-1:0] res_rs2,
    output logic            res_insn30,
    output logic [SEQW-1:0] res_seq,
    output logic [IW-1:0]   inflight,
    output logic            err_spurious
);
    localparam int SPW = $clog2(MAX_INFLIGHT);
    localparam int RPW = RES_DEPTH > 1 ? $clog2(RES_DEPTH) : 1;
    localparam int RCW = $clog2(RES_DEPTH + 1);
    localparam logic [IW-1:0] MAX_CNT = IW'(MAX_INFLIGHT);
    localparam logic [RCW-1:0] RES_CNT = RCW'(RES_DEPTH);
    localparam logic [RPW-1:0] RES_LAST = RPW'(RES_DEPTH - 1);

    logic [SEQW-1:0] seq;
    logic [XLEN-1:0] sh_rs1 [MAX_INFLIGHT];
    logic [XLEN-1:0] sh_rs2 [MAX_INFLIGHT];
    logic            sh_i30 [MAX_INFLIGHT];
    logic [SEQW-1:0] sh_seq [MAX_INFLIGHT];
    logic [SPW-1:0]  sh_wp, sh_rp;
    logic [XLEN-1:0] rf_rd  [RES_DEPTH];
    logic [XLEN-1:0] rf_rs1 [RES_DEPTH];
    logic [XLEN-1:0] rf_rs2 [RES_DEPTH];
    logic            rf_i30 [RES_DEPTH];
    logic [SEQW-1:0] rf_seq [RES_DEPTH];
    logic [RPW-1:0]  rf_wp, rf_rp;
    logic [RCW-1:0]  rf_cnt;
    logic cmd_fire, din_fire, dout_fire, retire, res_pop;

    function automatic logic [RPW-1:0] rinc(input logic [RPW-1:0] p);
        return p == RES_LAST ? '0 : p + 1'b1;
    endfunction

    // The shadow FIFO occupancy always equals inflight, so inflight==0 doubles as shadow-empty.
    always_comb begin
        cmd_ready  = reset && (!din_valid || din_ready) && inflight < MAX_CNT;
        cmd_fire   = cmd_valid && cmd_ready;
        din_fire   = din_valid && din_ready;
        dout_ready = rf_cnt < RES_CNT;
        dout_fire  = dout_valid && dout_ready;
        retire     = dout_fire && inflight != '0;
        res_valid  = rf_cnt != '0;
        res_pop    = res_valid && res_ready;
        res_rd     = rf_rd[rf_rp];
        res_rs1    = rf_rs1[rf_rp];
        res_rs2    = rf_rs2[rf_rp];
        res_insn30 = rf_i30[rf_rp];
        res_seq    = rf_seq[rf_rp];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            din_valid    <= 1'b0;
            seq          <= '0;
            inflight     <= '0;
            err_spurious <= 1'b0;
            sh_wp        <= '0;
            sh_rp        <= '0;
            rf_wp        <= '0;
            rf_rp        <= '0;
            rf_cnt       <= '0;
        end else begin
            din_valid    <= cmd_fire || (din_valid && !din_ready);
            seq          <= seq + SEQW'(cmd_fire);
            inflight     <= inflight + IW'(cmd_fire) - IW'(retire);
            err_spurious <= err_spurious || (dout_fire && inflight == '0);
            sh_wp        <= sh_wp + SPW'(cmd_fire);
            sh_rp        <= sh_rp + SPW'(retire);
            rf_wp        <= retire ? rinc(rf_wp) : rf_wp;
            rf_rp        <= res_pop ? rinc(rf_rp) : rf_rp;
            rf_cnt       <= rf_cnt + RCW'(retire) - RCW'(res_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (cmd_fire) begin
            din_rs1       <= cmd_rs1;
            din_rs2       <= cmd_rs2;
            din_insn30    <= cmd_insn30;
            sh_rs1[sh_wp] <= cmd_rs1;
            sh_rs2[sh_wp] <= cmd_rs2;
            sh_i30[sh_wp] <= cmd_insn30;
            sh_seq[sh_wp] <= seq;
        end
        if (retire) begin
            rf_rd[rf_wp]  <= dout_rd;
            rf_rs1[rf_wp] <= sh_rs1[sh_rp];
            rf_rs2[rf_wp] <= sh_rs2[sh_rp];
            rf_i30[rf_wp] <= sh_i30[sh_rp];
            rf_seq[rf_wp] <= sh_seq[sh_rp];
        end
    end
endmodule

// File: tb/tb_rvb_req_issuer.sv
// tb_rvb_req_issuer: scoreboard and vector-table bench for rvb_req_issuer with a behavioural compute unit.
module tb_rvb_req_issuer;
    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_insn30;
    logic [63:0] cmd_rs1, cmd_rs2;
    logic        din_valid, din_ready, din_insn30;
    logic [63:0] din_rs1, din_rs2;
    logic        dout_valid, dout_ready;
    logic [63:0] dout_rd;
    logic        res_valid, res_ready, res_insn30;
    logic [63:0] res_rd, res_rs1, res_rs2;
    logic [3:0]  res_seq;
    logic [2:0]  inflight;
    logic        err_spurious;

    rvb_req_issuer #(.XLEN(64), .MAX_INFLIGHT(4), .RES_DEPTH(2), .SEQW(4)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_insn30(cmd_insn30),
        .din_valid(din_valid), .din_ready(din_ready), .din_rs1(din_rs1), .din_rs2(din_rs2), .din_insn30(din_insn30),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_rd(dout_rd),
        .res_valid(res_valid), .res_ready(res_ready), .res_rd(res_rd), .res_rs1(res_rs1), .res_rs2(res_rs2),
        .res_insn30(res_insn30), .res_seq(res_seq), .inflight(inflight), .err_spurious(err_spurious)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [63:0] rd;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic        i30;
        logic [3:0]  seq;
    } res_t;

    typedef struct packed {
        logic       cv, dr, ov, rr;
        logic       crdy, dv;
        logic [2:0] inf;
        logic       ordy, rv;
    } vec_t;

    res_t         exp_q [$];
    logic [128:0] din_q [$];
    logic [63:0]  u_rd [$];
    int           u_t [$];
    int           tests = 0, fails = 0, cyc = 0;
    int           sent = 0, total = 0, lat = 0, pd = 100, pv = 100, pr = 100, used;
    logic [3:0]   exp_seq = '0;
    bit           auto_on = 0, last_cf = 0, d_hold = 0, r_hold = 0;
    logic [129:0] d_saved;
    logic [197:0] r_saved;
    logic [128:0] saved;
    vec_t         tbl [18];

    function automatic logic [63:0] gold(input logic [63:0] a, input logic [63:0] b, input logic i);
        return i ? a ^ {b[31:0], b[63:32]} : a + b;
    endfunction

    task automatic check(input string nm, input logic [199:0] act, input logic [199:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: unexpected transfer with empty scoreboard", nm);
    endtask

    task automatic observe();
        bit cf, df, of, rf;
        last_cf = 0;
        if (!reset) return;
        cf = cmd_valid && cmd_ready;
        df = din_valid && din_ready;
        of = dout_valid && dout_ready;
        rf = res_valid && res_ready;
        if (d_hold) check("din_stable", {din_valid, din_rs1, din_rs2, din_insn30}, d_saved);
        if (r_hold) check("res_stable", {res_valid, res_rd, res_rs1, res_rs2, res_insn30, res_seq}, r_saved);
        d_hold  = din_valid && !din_ready;
        d_saved = {1'b1, din_rs1, din_rs2, din_insn30};
        r_hold  = res_valid && !res_ready;
        r_saved = {1'b1, res_rd, res_rs1, res_rs2, res_insn30, res_seq};
        if (cf) begin
            din_q.push_back({cmd_rs1, cmd_rs2, cmd_insn30});
            exp_q.push_back('{gold(cmd_rs1, cmd_rs2, cmd_insn30), cmd_rs1, cmd_rs2, cmd_insn30, exp_seq});
            exp_seq = exp_seq + 4'd1;
        end
        if (df) begin
            if (din_q.size() == 0) fail_now("din_extra");
            else check("din_data", {din_rs1, din_rs2, din_insn30}, din_q.pop_front());
            u_rd.push_back(gold(din_rs1, din_rs2, din_insn30));
            u_t.push_back(cyc + lat);
        end
        if (of && u_rd.size() > 0) begin
            void'(u_rd.pop_front());
            void'(u_t.pop_front());
        end
        if (rf) begin
            if (exp_q.size() == 0) fail_now("res_extra");
            else check("res", {res_rd, res_rs1, res_rs2, res_insn30, res_seq}, exp_q.pop_front());
        end
        last_cf = cf;
    endtask

    task automatic drive();
        cyc++;
        if (last_cf || !cmd_valid) begin
            cmd_rs1    = {$urandom, $urandom};
            cmd_rs2    = {$urandom, $urandom};
            cmd_insn30 = 1'($urandom_range(1));
            if (auto_on) begin
                cmd_valid = sent < total;
                if (cmd_valid) sent++;
            end
        end
        if (auto_on) begin
            din_ready  = $urandom_range(99) < pd;
            res_ready  = $urandom_range(99) < pr;
            dout_valid = u_rd.size() > 0 && u_t[0] < cyc && $urandom_range(99) < pv;
        end
        dout_rd = u_rd.size() > 0 ? u_rd[0] : '0;
    endtask

    task automatic tick();
        observe();
        @(posedge clock);
        #1;
        drive();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        auto_on    = 0;
        cmd_valid  = 1'b1;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        res_ready  = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
            @(negedge clock);
            check("reset_state", {din_valid, res_valid, inflight, cmd_ready, err_spurious}, '0);
        end
        exp_q.delete();
        din_q.delete();
        u_rd.delete();
        u_t.delete();
        exp_seq = '0;
        d_hold  = 0;
        r_hold  = 0;
        last_cf = 0;
        sent    = 0;
        total   = 0;
        reset   = 1'b1;
        #1;
    endtask

    task automatic run(input int budget, output int n);
        n = 0;
        while (n < budget && !(sent == total && !cmd_valid && exp_q.size() == 0)) begin
            tick();
            n++;
        end
        check("drain_left", exp_q.size() + (total - sent) + int'(cmd_valid), 0);
        check("idle_state", {inflight, err_spurious, res_valid}, '0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // cv dr ov rr _ crdy dv _ inf _ ordy rv
        tbl[0]  = 11'b1100_10_000_10;
        tbl[1]  = 11'b1100_11_001_10;
        tbl[2]  = 11'b1100_11_010_10;
        tbl[3]  = 11'b1100_11_011_10;
        tbl[4]  = 11'b1100_01_100_10;
        tbl[5]  = 11'b1100_00_100_10;
        tbl[6]  = 11'b1110_00_100_10;
        tbl[7]  = 11'b1100_10_011_11;
        tbl[8]  = 11'b0110_01_100_11;
        tbl[9]  = 11'b0110_10_011_01;
        tbl[10] = 11'b0111_10_011_01;
        tbl[11] = 11'b0111_10_011_11;
        tbl[12] = 11'b0101_10_010_11;
        tbl[13] = 11'b0100_10_010_10;
        tbl[14] = 11'b0111_10_010_10;
        tbl[15] = 11'b0111_10_001_11;
        tbl[16] = 11'b0101_10_000_11;
        tbl[17] = 11'b0100_10_000_10;
        cmd_rs1 = '0; cmd_rs2 = '0; cmd_insn30 = 1'b0; dout_rd = '0;

        do_reset();
        check("post_reset_cmd_ready", cmd_ready, 1);
        saved = {cmd_rs1, cmd_rs2, cmd_insn30};
        tick();
        check("first_din", {din_valid, din_rs1, din_rs2, din_insn30}, {1'b1, saved});
        cmd_valid = 1'b0;
        auto_on = 1; pd = 100; pv = 100; pr = 100; lat = 0;
        run(200, used);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            cmd_valid  = tbl[i].cv;
            din_ready  = tbl[i].dr;
            dout_valid = tbl[i].ov;
            res_ready  = tbl[i].rr;
            #1;
            check($sformatf("vec%0d", i), {cmd_ready, din_valid, inflight, dout_ready, res_valid},
                  {tbl[i].crdy, tbl[i].dv, tbl[i].inf, tbl[i].ordy, tbl[i].rv});
            tick();
        end
        check("vec_scoreboard_empty", exp_q.size(), 0);

        do_reset();
        cmd_valid = 1'b0;
        auto_on = 1; total = 1000; pd = 100; pv = 100; pr = 100; lat = 0;
        run(3000, used);
        check("stream_cycles_ok", used <= 1010, 1);

        do_reset();
        cmd_valid = 1'b0;
        auto_on = 1; total = 300; pd = 75; pv = 75; pr = 87; lat = 8;
        run(20000, used);

        do_reset();
        cmd_valid  = 1'b0;
        res_ready  = 1'b1;
        dout_valid = 1'b1;
        #1;
        check("spur_dout_ready", dout_ready, 1);
        tick();
        dout_valid = 1'b0;
        #1;
        check("spur_set", {err_spurious, res_valid, inflight}, {1'b1, 1'b0, 3'd0});
        repeat (3) tick();
        check("spur_sticky", err_spurious, 1);
        cmd_valid = 1'b1;
        din_ready = 1'b1;
        tick();
        tick();
        cmd_valid = 1'b0;
        tick();
        check("midop_inflight", {inflight, din_valid}, {3'd2, 1'b0});
        do_reset();
        cmd_valid  = 1'b0;
        dout_valid = 1'b1;
        #1;
        tick();
        dout_valid = 1'b0;
        #1;
        check("late_beat_spur", {err_spurious, res_valid, inflight}, {1'b1, 1'b0, 3'd0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
